// File: rtl/logic_axi4_stream_merge_unit.sv
// Packet-atomic 2:1 AXI4-Stream merger with a registered output stage.
// Arbitration is round-robin or fixed-priority and only changes hands between packets.
module logic_axi4_stream_merge_unit #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int USE_TLAST   = 1,
    parameter int USE_TKEEP   = 1,
    parameter int USE_TSTRB   = 1,
    parameter int PRIORITY    = 0,
    localparam int DW = (TDATA_BYTES > 0) ? 8 * TDATA_BYTES : 1,
    localparam int KW = (TDATA_BYTES > 0) ? TDATA_BYTES : 1,
    localparam int UW = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1,
    localparam int EW = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1,
    localparam int IW = (TID_WIDTH > 0) ? TID_WIDTH : 1
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [1:0]         rx_tvalid,
    output logic [1:0]         rx_tready,
    input  logic [1:0][DW-1:0] rx_tdata,
    input  logic [1:0][KW-1:0] rx_tkeep,
    input  logic [1:0][KW-1:0] rx_tstrb,
    input  logic [1:0]         rx_tlast,
    input  logic [1:0][UW-1:0] rx_tuser,
    input  logic [1:0][EW-1:0] rx_tdest,
    input  logic [1:0][IW-1:0] rx_tid,
    output logic               tx_tvalid,
    input  logic               tx_tready,
    output logic [DW-1:0]      tx_tdata,
    output logic [KW-1:0]      tx_tkeep,
    output logic [KW-1:0]      tx_tstrb,
    output logic               tx_tlast,
    output logic [UW-1:0]      tx_tuser,
    output logic [EW-1:0]      tx_tdest,
    output logic [IW-1:0]      tx_tid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_rr_next;
    logic            w_rr_next_next;
    logic            r_tx_tvalid;
    logic            w_load;
    logic            w_grant;
    logic            w_xfer;
    logic [1:0]      w_last;

    logic [DW-1:0]   r_tdata;
    logic [KW-1:0]   r_tkeep;
    logic [KW-1:0]   r_tstrb;
    logic            r_tlast;
    logic [UW-1:0]   r_tuser;
    logic [EW-1:0]   r_tdest;
    logic [IW-1:0]   r_tid;

    // Without tlast every beat is a whole packet, so the FSM never locks.
    assign w_last = rx_tlast | ((USE_TLAST != 0) ? 2'b00 : 2'b11);
    assign w_load = !r_tx_tvalid || tx_tready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign rx_tready[gi] = !areset && w_load && (w_grant == 1'(gi));
        end
    endgenerate

    always_comb begin
        w_grant        = r_rr_next;
        w_xfer         = 1'b0;
        w_state_next   = r_state;
        w_rr_next_next = r_rr_next;

        // A locked packet owns the output whatever the other input does.
        case (r_state)
            ST_LOCK0: w_grant = 1'b0;
            ST_LOCK1: w_grant = 1'b1;
            default: begin
                if (PRIORITY != 0) begin
                    if (rx_tvalid[1]) begin
                        w_grant = 1'b1;
                    end else if (rx_tvalid[0]) begin
                        w_grant = 1'b0;
                    end
                end else if (!rx_tvalid[r_rr_next] && rx_tvalid[!r_rr_next]) begin
                    w_grant = !r_rr_next;
                end
            end
        endcase

        w_xfer = !areset && w_load && rx_tvalid[w_grant];

        if (w_xfer) begin
            if (w_last[w_grant]) begin
                w_state_next   = ST_IDLE;
                w_rr_next_next = !w_grant;
            end else begin
                w_state_next = w_grant ? ST_LOCK1 : ST_LOCK0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_rr_next   <= 1'b0;
            r_tx_tvalid <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rr_next <= w_rr_next_next;
            if (w_load) begin
                r_tx_tvalid <= w_xfer;
            end
        end
    end

    // Payload has no reset; it is only meaningful while tx_tvalid is high.
    always_ff @(posedge aclk) begin
        if (w_xfer) begin
            r_tdata <= rx_tdata[w_grant];
            r_tkeep <= rx_tkeep[w_grant];
            r_tstrb <= rx_tstrb[w_grant];
            r_tlast <= w_last[w_grant];
            r_tuser <= rx_tuser[w_grant];
            r_tdest <= rx_tdest[w_grant];
            r_tid   <= rx_tid[w_grant];
        end
    end

    assign tx_tvalid = r_tx_tvalid;
    assign tx_tdata  = (TDATA_BYTES > 0) ? r_tdata : '0;
    assign tx_tkeep  = (TDATA_BYTES > 0 && USE_TKEEP != 0) ? r_tkeep : '1;
    assign tx_tstrb  = (TDATA_BYTES > 0 && USE_TSTRB != 0) ? r_tstrb : '1;
    assign tx_tlast  = (USE_TLAST != 0) ? r_tlast : 1'b1;
    assign tx_tuser  = (TUSER_WIDTH > 0) ? r_tuser : '0;
    assign tx_tdest  = (TDEST_WIDTH > 0) ? r_tdest : '0;
    assign tx_tid    = (TID_WIDTH > 0) ? r_tid : '0;

endmodule

// File: tb/tb_logic_axi4_stream_merge_unit.sv
// Directed and randomized checks of the 2:1 packet merger against a packet-order model.
// Instance 0: round-robin, instance 1: fixed priority, instance 2: no tlast.
module tb_logic_axi4_stream_merge_unit;

    logic             aclk = 1'b0;
    logic             areset;
    logic [1:0]       rx_tvalid;
    logic [1:0][7:0]  rx_tdata;
    logic [1:0][0:0]  rx_tkeep;
    logic [1:0][0:0]  rx_tstrb;
    logic [1:0]       rx_tlast;
    logic [1:0][0:0]  rx_tuser;
    logic [1:0][0:0]  rx_tdest;
    logic [1:0][0:0]  rx_tid;
    logic             tx_tready;

    logic [1:0] o_rdy [3];
    logic       o_tv  [3];
    logic [7:0] o_td  [3];
    logic       o_tk  [3];
    logic       o_ts  [3];
    logic       o_tl  [3];
    logic       o_tu  [3];
    logic       o_te  [3];
    logic       o_ti  [3];

    always #5 aclk = ~aclk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            logic_axi4_stream_merge_unit #(
                .PRIORITY  ((gi == 1) ? 1 : 0),
                .USE_TLAST ((gi == 2) ? 0 : 1)
            ) u_dut (
                .aclk      (aclk),
                .areset    (areset),
                .rx_tvalid (rx_tvalid),
                .rx_tready (o_rdy[gi]),
                .rx_tdata  (rx_tdata),
                .rx_tkeep  (rx_tkeep),
                .rx_tstrb  (rx_tstrb),
                .rx_tlast  (rx_tlast),
                .rx_tuser  (rx_tuser),
                .rx_tdest  (rx_tdest),
                .rx_tid    (rx_tid),
                .tx_tvalid (o_tv[gi]),
                .tx_tready (tx_tready),
                .tx_tdata  (o_td[gi]),
                .tx_tkeep  (o_tk[gi]),
                .tx_tstrb  (o_ts[gi]),
                .tx_tlast  (o_tl[gi]),
                .tx_tuser  (o_tu[gi]),
                .tx_tdest  (o_te[gi]),
                .tx_tid    (o_ti[gi])
            );
        end
    endgenerate

    int          n_vec = 0;
    int          n_err = 0;
    int          sel = 0;
    int          rdy_mode = 0;
    int          cyc = 0;
    int          first_tx = -1;
    int          last_tx = -1;
    logic [1:0]  en = 2'b00;
    logic [1:0]  last_rdy;
    logic        last_tv;
    logic        prev_stall = 1'b0;
    logic [13:0] prev_obs;

    // Source queues hold {tlast, tdata}; the model queue holds {source, tlast, tdata}
    // in the order the merged stream must produce them.
    logic [8:0]  q0 [$];
    logic [8:0]  q1 [$];
    logic [9:0]  exp_q [$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [13:0] exp_obs(logic [9:0] e);
        return {e[9], e[8], e[7:0], ~e[0], e[1], 2'b11};
    endfunction

    task automatic add_pkt(int src, int len, int n_exp, bit nolast);
        logic [7:0] d;
        logic       l;
        for (int k = 0; k < len; k++) begin
            d = 8'($urandom);
            l = (k == len - 1);
            if (src == 0) q0.push_back({nolast ? 1'b0 : l, d});
            else          q1.push_back({nolast ? 1'b0 : l, d});
            if (k < n_exp) exp_q.push_back({1'(src), nolast ? 1'b1 : l, d});
        end
    endtask

    task automatic clear();
        q0.delete();
        q1.delete();
        exp_q.delete();
        cyc = 0;
        first_tx = -1;
        last_tx = -1;
    endtask

    task automatic tick();
        logic [13:0] obs;
        logic [8:0]  b;
        logic        have;
        case (rdy_mode)
            0:       tx_tready = 1'b1;
            1:       tx_tready = ~cyc[0];
            default: tx_tready = ($urandom_range(0, 9) < 7);
        endcase
        for (int i = 0; i < 2; i++) begin
            have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
            b = 9'($urandom);
            if (have) b = (i == 0) ? q0[0] : q1[0];
            rx_tvalid[i] = en[i] && have;
            rx_tdata[i]  = b[7:0];
            rx_tlast[i]  = b[8];
            rx_tuser[i]  = ~b[0];
            rx_tdest[i]  = b[1];
            rx_tid[i]    = 1'(i);
            rx_tkeep[i]  = 1'b1;
            rx_tstrb[i]  = 1'b1;
        end
        #1;
        last_rdy = o_rdy[sel];
        last_tv  = o_tv[sel];
        obs = {o_ti[sel], o_tl[sel], o_td[sel], o_tu[sel], o_te[sel], o_tk[sel], o_ts[sel]};
        if (prev_stall) begin
            chk("stall_hold_valid", 32'(last_tv), 32'd1);
            chk("stall_hold_payload", 32'(obs), 32'(prev_obs));
        end
        if (last_tv === 1'b1 && tx_tready) begin
            $display("tx inst=%0d cyc=%0d src=%0d data=%02h last=%0d", sel, cyc, obs[13], obs[11:4], obs[12]);
            if (first_tx < 0) first_tx = cyc;
            last_tx = cyc;
            if (exp_q.size() > 0) chk("beat", 32'(obs), 32'(exp_obs(exp_q.pop_front())));
            else                  chk("extra_beat", 32'(exp_q.size()), 32'd1);
        end
        if (rx_tvalid[0] && last_rdy[0]) void'(q0.pop_front());
        if (rx_tvalid[1] && last_rdy[1]) void'(q1.pop_front());
        prev_stall = (last_tv === 1'b1) && !tx_tready && !areset;
        prev_obs = obs;
        @(posedge aclk);
        @(negedge aclk);
        cyc++;
    endtask

    task automatic do_reset(int n);
        prev_stall = 1'b0;
        areset = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            chk("reset_rx_tready", 32'(last_rdy), 32'd0);
            if (k > 0) chk("reset_tx_tvalid", 32'(last_tv), 32'd0);
        end
        areset = 1'b0;
    endtask

    task automatic drain(string tag, int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
    endtask

    initial begin
        areset = 1'b1;
        tx_tready = 1'b1;
        rx_tvalid = '0;

        // Reset with both inputs valid; first beat afterwards comes from rx 0.
        sel = 0;
        clear();
        add_pkt(0, 1, 1, 0);
        add_pkt(1, 1, 1, 0);
        en = 2'b11;
        do_reset(2);
        drain("reset_rr", 20);

        // Interleave: A0..A2 then B0..B1 back-to-back with 1-cycle latency.
        do_reset(1);
        clear();
        add_pkt(0, 3, 3, 0);
        add_pkt(1, 2, 2, 0);
        drain("interleave", 20);
        chk("first_beat_cycle", 32'(first_tx), 32'd1);
        chk("last_beat_cycle", 32'(last_tx), 32'd5);

        // Lock hold: rx 1 arrives mid-packet and waits for rx 0 tlast.
        do_reset(1);
        clear();
        en = 2'b01;
        add_pkt(0, 4, 4, 0);
        add_pkt(1, 2, 2, 0);
        tick();
        en = 2'b11;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("lock_rx1_tready", 32'(last_rdy[1]), 32'd0);
        end
        tick();
        chk("unlock_rx1_tready", 32'(last_rdy[1]), 32'd1);
        drain("lock_hold", 20);

        // Backpressure: tx_tready toggles 1010 through a 4-beat packet.
        do_reset(1);
        clear();
        rdy_mode = 1;
        en = 2'b01;
        add_pkt(0, 4, 4, 0);
        drain("backpressure", 40);

        // Random: both inputs always valid, random lengths and random tx_tready;
        // whole packets must alternate starting with rx 0.
        rdy_mode = 0;
        do_reset(1);
        clear();
        rdy_mode = 2;
        en = 2'b11;
        for (int p = 0; p < 12; p++) begin
            add_pkt(0, int'($urandom_range(1, 4)), 4, 0);
            add_pkt(1, int'($urandom_range(1, 4)), 4, 0);
        end
        drain("random_rr", 600);

        // Fixed priority: rx 1 streams single beats and rx 0 starves.
        rdy_mode = 0;
        sel = 1;
        do_reset(1);
        clear();
        en = 2'b11;
        for (int p = 0; p < 8; p++) begin
            add_pkt(1, 1, 1, 0);
            add_pkt(0, 1, 0, 0);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("priority_rx0_starved", 32'(last_rdy[0]), 32'd0);
        end
        en = 2'b00;
        drain("priority", 20);

        // No tlast: single-beat packets alternate and tx_tlast is always 1.
        sel = 2;
        do_reset(1);
        clear();
        en = 2'b11;
        for (int p = 0; p < 4; p++) begin
            add_pkt(0, 1, 1, 1);
            add_pkt(1, 1, 1, 1);
        end
        drain("no_tlast", 30);

        // Reset during beat 2 of a 4-beat rx 1 packet must drop the lock.
        sel = 0;
        do_reset(1);
        clear();
        en = 2'b10;
        add_pkt(1, 4, 2, 0);
        tick();
        tick();
        do_reset(1);
        clear();
        en = 2'b11;
        add_pkt(0, 1, 1, 0);
        add_pkt(1, 1, 1, 0);
        drain("reset_mid_pkt", 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
